prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
Byte-stream program loader that writes the 16-bit x 4096-word instruction BRAM through its single write port (data/wren/address), at power-up or on request. Consumes a framed byte stream from the UART receiver using a valid/ready handshake, assembles big-endian words and writes them to consecutive addresses from 0. Holds the CPU off while busy. Checks a trailing XOR checksum and reports done or error.

Parameters:
ADDR_W, 12, BRAM address width; DEPTH = 2**ADDR_W words (4096).
DATA_W, 16, BRAM word width; fixed at two bytes per word, big-endian.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a load when not busy
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader accepts byte this cycle (transfer = rx_valid & rx_ready)
mem_data  output  DATA_W  to BRAM data
mem_wren  output  1  to BRAM wren
mem_addr  output  ADDR_W  to BRAM address
busy  output  1  load in progress; CPU held in reset while high
done  output  1  sticky: last load completed with good checksum
err  output  1  sticky: last load failed (bad length or checksum)
words_loaded  output  ADDR_W+1  count of words written in current/last load

Behaviour:
- Reset (async, rst_n low): state IDLE; rx_ready=0, mem_wren=0, mem_data=0, mem_addr=0, busy=0, done=0, err=0, words_loaded=0. Reset mid-load aborts immediately; words already written stay in BRAM.
- All outputs are registered.
- Frame: LEN_HI, LEN_LO (16-bit word count N), then 2N data bytes (high byte first), then 1 checksum byte = XOR of every preceding frame byte, length bytes included.
- States: IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, CHK, DONE, ERR.
- IDLE/DONE/ERR: start -> LEN_HI; clear done, err, words_loaded and the running XOR; set busy. start ignored in every other state.
- rx_ready=1 only in LEN_HI, LEN_LO, DAT_HI, DAT_LO, CHK. Each transfer advances one state and XORs the byte into the running checksum (except the CHK byte itself).
- LEN_LO transfer: N=0 or N>DEPTH -> ERR, no writes; otherwise -> DAT_HI.
- DAT_LO transfer: register mem_data={hi,byte} and mem_addr=word index; -> WRITE.
- WRITE: exactly one cycle with mem_wren=1, rx_ready=0. On exit, index and words_loaded increment. Index==N -> CHK, else -> DAT_HI.
- CHK transfer: byte equals running XOR -> DONE (done=1), else -> ERR (err=1). busy=0 in both.
- mem_wren is never high outside WRITE. mem_addr holds its last value otherwise. Maximum write rate is one word per 3 cycles.
- rx_valid low stalls any receive state indefinitely; no timeout.
- N=DEPTH writes addresses 0..4095. The index is ADDR_W+1 bits wide so the compare cannot wrap.

Decomposition:
- Package loader_pkg: state enum, FRAME_HDR_BYTES=2, BYTES_PER_WORD=2, DEPTH derived from ADDR_W.
- Single module; no sub-module warranted. The checksum accumulator is inline.

Test Plan:
- start, then bytes 00 02 80 20 81 03 20 -> writes 0x8020@0 and 0x8103@1, one mem_wren cycle each; done=1, err=0, words_loaded=2, busy drops.
- Same frame with checksum 0x21 -> both words written, err=1, done=0.
- Length 00 00, and separately 10 01 (4097) -> ERR right after LEN_LO; mem_wren never asserts.
- Random rx_valid gaps plus a start pulse mid-load -> identical BRAM contents; the extra start is ignored; rx_ready low during WRITE.
- rst_n low after 1 of 3 words -> all outputs at reset values asynchronously. A new start then reloads correctly from address 0.
- N=4096 with an incrementing pattern -> last write at 0xFFF, words_loaded=4096, done=1.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the program loader: the FSM state encoding, frame
// layout constants and small helpers used by the loader and its bench.
// ---------------------------------------------------------------------------
package loader_pkg;

    // Loader FSM states, one per frame field plus the write cycle and the
    // three resting states (idle, finished good, finished bad).
    typedef enum logic [3:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DAT_HI,
        DAT_LO,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_e;

    localparam int FRAME_HDR_BYTES = 2;
    localparam int BYTES_PER_WORD  = 2;
    localparam int ADDR_W_DEFAULT  = 12;
    localparam int DEPTH           = 1 << ADDR_W_DEFAULT;

    // Number of BRAM words addressable with the given address width.
    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    // States in which the loader is willing to take a byte from the UART.
    function automatic logic is_rx_state(input state_e s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DAT_HI) ||
               (s == DAT_LO) || (s == CHK);
    endfunction

endpackage

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
// Loads the instruction BRAM from a framed UART byte stream. Frame layout:
// LEN_HI, LEN_LO (word count N), 2N data bytes (big-endian words), then one
// checksum byte equal to the XOR of every earlier frame byte. Words go to
// consecutive addresses starting at 0. The CPU is held off while busy.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   start           one-cycle pulse; begins a load when not busy
//   rx_data/valid   incoming byte stream from the UART receiver
//   rx_ready        loader accepts a byte this cycle
//   mem_data/wren/addr  BRAM write port
//   busy            load in progress
//   done / err      sticky result of the last load
//   words_loaded    words written in the current/last load
// All outputs are registered.
// ---------------------------------------------------------------------------
module prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int MEM_DEPTH = depth_of(ADDR_W);
    localparam int CNT_W     = ADDR_W + 1;

    state_e             state_q, state_d;
    logic [7:0]         xor_q, xor_d;
    logic [7:0]         hi_q, hi_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic               rx_ready_q, rx_ready_d;
    logic [DATA_W-1:0]  mem_data_q, mem_data_d;
    logic               mem_wren_q, mem_wren_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   words_q, words_d;

    logic               xfer;
    logic [15:0]        len_word;
    logic               len_bad;
    logic [CNT_W-1:0]   idx_inc;

    // rx_ready is registered from the next state, so it always matches the
    // current state and can qualify the handshake directly.
    assign xfer     = rx_valid & rx_ready_q;
    assign len_word = {hi_q, rx_data};
    // Index is one bit wider than the address so N == DEPTH compares cleanly.
    assign len_bad  = (len_word == 16'd0) ||
                      ({16'd0, len_word} > 32'(MEM_DEPTH));
    assign idx_inc  = idx_q + CNT_W'(1);

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            xor_q      <= '0;
            hi_q       <= '0;
            n_q        <= '0;
            idx_q      <= '0;
            rx_ready_q <= 1'b0;
            mem_data_q <= '0;
            mem_wren_q <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            xor_q      <= xor_d;
            hi_q       <= hi_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            rx_ready_q <= rx_ready_d;
            mem_data_q <= mem_data_d;
            mem_wren_q <= mem_wren_d;
            mem_addr_q <= mem_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            words_q    <= words_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        xor_d      = xor_q;
        hi_d       = hi_q;
        n_d        = n_q;
        idx_d      = idx_q;
        mem_data_d = mem_data_q;
        mem_addr_d = mem_addr_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        words_d    = words_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN_HI;
                    xor_d   = '0;
                    idx_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    words_d = '0;
                    busy_d  = 1'b1;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    hi_d    = rx_data;
                    xor_d   = xor_q ^ rx_data;
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    xor_d = xor_q ^ rx_data;
                    if (len_bad) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        n_d     = len_word[CNT_W-1:0];
                        state_d = DAT_HI;
                    end
                end
            end
            DAT_HI: begin
                if (xfer) begin
                    hi_d    = rx_data;
                    xor_d   = xor_q ^ rx_data;
                    state_d = DAT_LO;
                end
            end
            DAT_LO: begin
                if (xfer) begin
                    xor_d      = xor_q ^ rx_data;
                    mem_data_d = DATA_W'({hi_q, rx_data});
                    mem_addr_d = idx_q[ADDR_W-1:0];
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                idx_d   = idx_inc;
                words_d = words_q + CNT_W'(1);
                state_d = (idx_inc == n_q) ? CHK : DAT_HI;
            end
            CHK: begin
                if (xfer) begin
                    busy_d = 1'b0;
                    if (rx_data == xor_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Strobes follow the state being entered so the registered copies
        // line up with the state register.
        rx_ready_d = is_rx_state(state_d);
        mem_wren_d = (state_d == WRITE);
    end

    assign rx_ready     = rx_ready_q;
    assign mem_data     = mem_data_q;
    assign mem_wren     = mem_wren_q;
    assign mem_addr     = mem_addr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
// Self-checking bench for prog_loader. Frames are built in a byte queue; a
// frame-level model derives the expected BRAM writes and final status, and a
// monitor compares every write cycle against the expected-write queue.
// ---------------------------------------------------------------------------
module tb_prog_loader;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4096;

    typedef logic [7:0] byte_t;
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [ADDR_W-1:0] mem_addr;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    int     errors = 0;
    int     checks = 0;
    int     wr_count = 0;
    byte_t  frame_q[$];
    wr_t    exp_q[$];
    wr_t    mon_e;
    logic [DATA_W-1:0] bram [0:DEPTH-1];

    prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .mem_data     (mem_data),
        .mem_wren     (mem_wren),
        .mem_addr     (mem_addr),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // XOR of the first cnt bytes of the current frame.
    function automatic byte_t xor_of(input int cnt);
        byte_t x = 8'h00;
        for (int i = 0; i < cnt; i++) x ^= frame_q[i];
        return x;
    endfunction

    // Every write cycle must match the next expected write, with rx_ready low.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("done_err_exclusive", {31'd0, done & err}, 32'd0);
            if (mem_wren) begin
                bram[mem_addr] = mem_data;
                wr_count++;
                checkOutput("rx_ready_in_write", {31'd0, rx_ready}, 32'd0);
                checkOutput("write_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    checkOutput("write_addr", 32'(mem_addr), 32'(mon_e.addr));
                    checkOutput("write_data", 32'(mem_data), 32'(mon_e.data));
                end
            end
        end
    end

    task automatic build_frame(input int n, input bit incr, input bit bad_chk);
        logic [15:0] w;
        logic [15:0] nn;
        byte_t x;
        nn = 16'(n);
        frame_q.delete();
        frame_q.push_back(nn[15:8]);
        frame_q.push_back(nn[7:0]);
        for (int i = 0; i < n; i++) begin
            w = incr ? 16'(i) : 16'($urandom);
            frame_q.push_back(w[15:8]);
            frame_q.push_back(w[7:0]);
        end
        x = xor_of(frame_q.size());
        if (bad_chk) x ^= 8'(1 + $urandom_range(254));
        frame_q.push_back(x);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic send_byte(input byte_t b, input int gap_pct);
        bit taken = 1'b0;
        int guard = 0;
        while (!taken) begin
            @(negedge clk);
            if ($urandom_range(99) < 32'(gap_pct)) begin
                rx_valid = 1'b0;
            end else begin
                rx_valid = 1'b1;
                rx_data  = b;
                if (rx_ready) taken = 1'b1;
            end
            guard++;
            if (guard > 1000) begin
                checks++;
                errors++;
                $display("[TB] FAIL send_byte_timeout: byte 0x%0h not accepted in %0d cycles", b, guard);
                return;
            end
        end
    endtask

    // Runs the frame in frame_q through the DUT and checks the final status
    // against what the frame rules say must happen.
    task automatic applyStimulus(input bit mid_start, input int gap_pct);
        int    n;
        bit    bad_len;
        int    consumed;
        bit    exp_done;
        int    exp_words;
        int    wr0;
        int    guard;
        n        = {frame_q[0], frame_q[1]};
        bad_len  = (n == 0) || (n > DEPTH);
        consumed = bad_len ? 2 : 2 * n + 3;
        exp_words = bad_len ? 0 : n;
        exp_done = !bad_len && (frame_q[consumed-1] == xor_of(consumed - 1));
        if (!bad_len)
            for (int i = 0; i < n; i++)
                exp_q.push_back('{addr: ADDR_W'(i),
                                  data: {frame_q[2+2*i], frame_q[3+2*i]}});
        wr0 = wr_count;

        pulse_start();
        checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
        checkOutput("ready_after_start", {31'd0, rx_ready}, 32'd1);
        checkOutput("done_cleared", {31'd0, done}, 32'd0);
        checkOutput("err_cleared", {31'd0, err}, 32'd0);
        checkOutput("words_cleared", 32'(words_loaded), 32'd0);

        for (int k = 0; k < consumed; k++) begin
            if (mid_start && k == 3 && consumed > 4) pulse_start();
            send_byte(frame_q[k], gap_pct);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        guard = 0;
        while (busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("busy_end", {31'd0, busy}, 32'd0);
        checkOutput("done_end", {31'd0, done}, {31'd0, exp_done});
        checkOutput("err_end", {31'd0, err}, {31'd0, !exp_done});
        checkOutput("words_end", 32'(words_loaded), 32'(exp_words));
        checkOutput("write_count", 32'(wr_count - wr0), 32'(exp_words));
        checkOutput("exp_writes_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("ready_end", {31'd0, rx_ready}, 32'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        checkOutput({tag, "_mem_wren"}, {31'd0, mem_wren}, 32'd0);
        checkOutput({tag, "_mem_data"}, 32'(mem_data), 32'd0);
        checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_err"}, {31'd0, err}, 32'd0);
        checkOutput({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        int wr0;
        int guard;

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Reference frame with correct checksum.
        frame_q = '{8'h00, 8'h02, 8'h80, 8'h20, 8'h81, 8'h03, 8'h20};
        checkOutput("lit_model_xor", 32'(xor_of(6)), 32'h20);
        applyStimulus(1'b0, 0);
        checkOutput("lit_bram0", 32'(bram[0]), 32'h8020);
        checkOutput("lit_bram1", 32'(bram[1]), 32'h8103);
        checkOutput("lit_done", {31'd0, done}, 32'd1);
        checkOutput("lit_words2", 32'(words_loaded), 32'd2);

        // Same frame, wrong checksum.
        frame_q = '{8'h00, 8'h02, 8'h80, 8'h20, 8'h81, 8'h03, 8'h21};
        applyStimulus(1'b0, 0);
        checkOutput("lit_err_badchk", {31'd0, err}, 32'd1);

        // Illegal lengths.
        frame_q = '{8'h00, 8'h00};
        applyStimulus(1'b0, 20);
        checkOutput("lit_err_len0", {31'd0, err}, 32'd1);
        frame_q = '{8'h10, 8'h01};
        applyStimulus(1'b0, 20);
        checkOutput("lit_err_len4097", {31'd0, err}, 32'd1);

        // Random frames with valid gaps, some with a stray start mid-load.
        for (int f = 0; f < 10; f++) begin
            build_frame($urandom_range(1, 8), 1'b0, $urandom_range(3) == 0);
            applyStimulus(f % 2 == 1, 30);
        end

        // Reset after the first of three words.
        build_frame(3, 1'b0, 1'b0);
        exp_q.push_back('{addr: '0, data: {frame_q[2], frame_q[3]}});
        wr0 = wr_count;
        pulse_start();
        for (int k = 0; k < 4; k++) send_byte(frame_q[k], 0);
        @(negedge clk);
        rx_valid = 1'b0;
        guard = 0;
        while (wr_count == wr0 && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
        end
        checkOutput("abort_first_write", 32'(wr_count - wr0), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        build_frame(3, 1'b0, 1'b0);
        applyStimulus(1'b0, 10);

        // Full-depth load with an incrementing pattern.
        build_frame(DEPTH, 1'b1, 1'b0);
        applyStimulus(1'b0, 0);
        checkOutput("lit_words_4096", 32'(words_loaded), 32'd4096);
        checkOutput("lit_bram_last", 32'(bram[ADDR_W'(DEPTH-1)]), 32'h0FFF);
        checkOutput("lit_done_4096", {31'd0, done}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
